// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: width/reset defaults, opcode constants
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory request/response, redirect and IF/ID
// channels. master = fetch unit side, slave = memory/execute/decode side.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_opcode,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_opcode,
    output id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers the result in the IF/ID register and squashes fetches on redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;

  logic            w_req_valid;
  logic            w_fire;
  logic [XLEN-1:0] w_redir_pc;

  // Only request when the IF/ID slot will be free by the time the response
  // lands, so a response never has to wait for the consumer.
  assign w_req_valid = (r_state == ST_REQ) && !bus.redirect_valid
                       && (!r_id_valid || bus.id_ready);
  assign w_fire      = w_req_valid && bus.imem_req_ready;
  assign w_redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = r_id_valid;
  assign bus.id_instr       = r_id_instr;
  assign bus.id_pc          = r_id_pc;
  assign bus.id_opcode      = r_id_valid ? r_id_instr[6:0] : 7'b0000000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_id_valid    <= 1'b0;
      r_id_instr    <= '0;
      r_id_pc       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
        end

        ST_REQ: begin
          if (bus.redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_id_valid <= 1'b0;
          end else begin
            if (bus.id_ready) r_id_valid <= 1'b0;
            if (w_fire) begin
              r_inflight_pc <= r_pc;
              r_state       <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (bus.redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_id_valid <= 1'b0;
            r_state    <= bus.imem_rsp_valid ? ST_REQ : ST_DROP;
          end else if (bus.imem_rsp_valid) begin
            r_id_valid <= 1'b1;
            r_id_instr <= bus.imem_rsp_data;
            r_id_pc    <= r_inflight_pc;
            r_pc       <= r_pc + XLEN'(4);
            r_state    <= ST_REQ;
          end else if (bus.id_ready) begin
            r_id_valid <= 1'b0;
          end
        end

        ST_DROP: begin
          // The squashed response is still owed; swallow it before refetching.
          if (bus.redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_id_valid <= 1'b0;
          end else if (bus.id_ready) begin
            r_id_valid <= 1'b0;
          end
          if (bus.imem_rsp_valid) r_state <= ST_REQ;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the opcode decoder (control unit). It owns the PC and issues one instruction-memory request at a time over a valid/ready request channel with a fixed-order response. It buffers each returned instruction in a single IF/ID output register and presents its opcode field to the decoder. It also handles downstream stalls and branch/jump redirects, including squashing an in-flight fetch.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  instruction memory accepts request
imem_req_addr  output  XLEN  fetch address (current PC)
imem_rsp_valid  input  1  response valid; no backpressure on this channel
imem_rsp_data  input  32  returned instruction word
redirect_valid  input  1  taken branch/JAL/JALR from execute
redirect_pc  input  XLEN  redirect target
id_valid  output  1  IF/ID register holds a valid instruction
id_ready  input  1  downstream consumes the instruction this cycle
id_instr  output  32  buffered instruction
id_pc  output  XLEN  PC of the buffered instruction
id_opcode  output  7  id_valid ? id_instr[6:0] : 7'b0000000

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - state=IDLE, pc=RESET_PC, inflight_pc=0.
  - id_valid=0, id_instr=0, id_pc=0.
  - imem_req_valid=0.
- Encoding and arithmetic:
  - States: IDLE, REQ, WAIT, DROP.
  - At most one request outstanding at any time.
  - id_opcode=0 when the register is empty. The decoder maps 0 to its default (no RegWrite/MemWrite/Branch), so bubbles are harmless.
  - PC increment is pc+4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
  - redirect_pc[1:0] is forced to 2'b00 before use.
- Request gating:
  - imem_req_valid = (state==REQ) && !redirect_valid && (!id_valid || id_ready).
  - imem_req_addr = pc.
  - Fire = imem_req_valid && imem_req_ready.
  - This gating guarantees the output register is empty when the response lands.
  - While stalled by imem_req_ready=0, addr is held stable.
- Transitions:
  - IDLE -> REQ unconditionally (first cycle after reset release).
  - REQ: on fire, inflight_pc<=pc and go to WAIT.
  - WAIT, imem_rsp_valid=1 and no redirect:
    - id_valid<=1, id_instr<=imem_rsp_data, id_pc<=inflight_pc.
    - pc<=pc+4, go to REQ.
  - WAIT, redirect_valid=1 and imem_rsp_valid=0: go to DROP.
  - WAIT, redirect_valid=1 and imem_rsp_valid=1 in the same cycle: discard the response, go to REQ.
  - DROP: imem_rsp_valid=1 discards the data and goes to REQ. A further redirect updates pc and stays in DROP.
- Redirect (any state other than IDLE):
  - pc <= aligned redirect_pc; id_valid <= 0 (flush).
  - Redirect beats a simultaneous id_ready and a simultaneous response.
- Output consume:
  - id_valid && id_ready && no new response: id_valid<=0.
  - id_ready while id_valid=0 has no effect.
  - Throughput: 1 instruction per 2 cycles with zero-wait memory.
- Error handling:
  - imem_rsp_valid in IDLE or REQ is a protocol error. It is ignored, with no state change.
  - Reset asserted mid-WAIT abandons the fetch. A response arriving after reset release, while in IDLE or REQ, is ignored per the rule above.

Decomposition:
- Package riscv_pkg holds:
  - XLEN and RESET_PC defaults.
  - NOP constant 32'h0000_0013.
  - Opcode constants: OP_R 0110011, OP_I 0010011, OP_S 0100011, OP_L 0000011, OP_B 1100011, OP_JAL 1101111, OP_JALR 1100111.
  - Fetch state enum.
- Single module; no sub-module is warranted.

Test Plan:
1. Release rst, imem_req_ready=1, respond 0x00500093 one cycle after fire -> first req addr 0x0; id_valid=1, id_pc=0, id_opcode=0010011; next req addr 0x4.
2. Hold id_ready=0 with id_valid=1 for 4 cycles -> imem_req_valid=0, id_instr unchanged. Raise id_ready -> request to 0x4 issued that same cycle.
3. Hold imem_req_ready=0 for 3 cycles in REQ -> imem_req_valid=1 and addr stable throughout; fire on cycle 4.
4. Redirect to 0x100 in WAIT, response 2 cycles later -> response dropped, id_valid stays 0, next req addr 0x100. Repeat with redirect and response in the same cycle -> same result.
5. Redirect to 0x103 -> next req addr 0x100. Redirect to 0xFFFFFFFC, respond -> following req addr 0x0.
6. Assert rst mid-WAIT with no clock edge -> id_valid=0 and imem_req_valid=0 immediately. Send a stale response after release -> ignored; first req goes to RESET_PC.
